// File: rtl/instruction_fetch.sv
// instruction_fetch: accepts PCs and fetches them one at a time over req/ack.
// It queues {instr, pc} pairs in a DEPTH-entry FIFO for decode.
// Ports: Clk, Rst (async, active-low); PCIn/PCValid/PCReady from the PC;
//   Flush redirect; MemReq/MemAddr/MemAck/MemData to instruction memory;
//   InstrValid/Instr/InstrPC/InstrReady to decode.
// Build option FETCH_ALIGN_CHECK_EN: misaligned PCs skip memory and push a
//   faulting entry; adds the InstrFault output.
module instruction_fetch #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [ADDR_W-1:0]  PCIn,
  input  logic               PCValid,
  output logic               PCReady,
  input  logic               Flush,
  output logic               MemReq,
  output logic [ADDR_W-1:0]  MemAddr,
  input  logic               MemAck,
  input  logic [INSTR_W-1:0] MemData,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic               InstrFault,
`endif
  output logic               InstrValid,
  output logic [INSTR_W-1:0] Instr,
  output logic [ADDR_W-1:0]  InstrPC,
  input  logic               InstrReady
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CONE = (PW+1)'(1);
  localparam logic [PW-1:0] PONE = PW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [PW:0]        cnt_q, cnt_d;
  logic [PW-1:0]      rd_q, wr_q;
  logic               run_q;
  logic [INSTR_W-1:0] ins_q [DEPTH];
  logic [ADDR_W-1:0]  pc_q  [DEPTH];
`ifdef FETCH_ALIGN_CHECK_EN
  logic               flt_q [DEPTH];
`endif

  logic               pc_rdy;
  logic               req;
  logic               accept;
  logic               push;
  logic               pop;
  logic [INSTR_W-1:0] push_ins;
  logic [ADDR_W-1:0]  push_pc;
  logic               push_flt;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    pc_rdy   = 1'b0;
    req      = 1'b0;
    push     = 1'b0;
    push_ins = MemData;
    push_pc  = addr_q;
    push_flt = 1'b0;
    unique case (state_q)
      IDLE: begin
        pc_rdy = run_q & ~Flush & (cnt_q < FULL);
      end
      REQ: begin
        req = 1'b1;
        if (MemAck) begin
          push    = ~Flush;
          state_d = IDLE;
`ifndef FETCH_ALIGN_CHECK_EN
          // Back-to-back: the next PC may claim a slot on the push edge,
          // as long as one remains after this push.
          pc_rdy = run_q & ~Flush & (cnt_q < FULL - CONE);
`endif
        end else if (Flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        req = 1'b1;
        if (MemAck) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    accept = PCValid & pc_rdy;
    if (accept) begin
`ifdef FETCH_ALIGN_CHECK_EN
      // Only reachable from IDLE here, so a fault push never
      // coincides with a memory push.
      if (PCIn[1:0] != 2'b00) begin
        push     = 1'b1;
        push_ins = '0;
        push_pc  = PCIn;
        push_flt = 1'b1;
        state_d  = IDLE;
      end else begin
        addr_d  = PCIn;
        state_d = REQ;
      end
`else
      addr_d      = PCIn;
      addr_d[1:0] = 2'b00;
      state_d     = REQ;
`endif
    end
  end

  assign pop = (cnt_q != '0) & InstrReady & ~Flush;

  always_comb begin
    cnt_d = cnt_q;
    if (Flush)             cnt_d = '0;
    else if (push && !pop) cnt_d = cnt_q + CONE;
    else if (!push && pop) cnt_d = cnt_q - CONE;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      run_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        ins_q[i] <= '0;
        pc_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      run_q   <= 1'b1;
      if (Flush) begin
        rd_q <= '0;
        wr_q <= '0;
      end else begin
        if (push) begin
          ins_q[wr_q] <= push_ins;
          pc_q[wr_q]  <= push_pc;
          wr_q        <= wr_q + PONE;
        end
        if (pop) rd_q <= rd_q + PONE;
      end
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < DEPTH; i++) flt_q[i] <= 1'b0;
    end else if (push && !Flush) begin
      flt_q[wr_q] <= push_flt;
    end
  end

  assign InstrFault = InstrValid & flt_q[rd_q];
`endif

  assign PCReady    = pc_rdy;
  assign MemReq     = req;
  assign MemAddr    = addr_q;
  assign InstrValid = (cnt_q != '0);
  assign Instr      = InstrValid ? ins_q[rd_q] : '0;
  assign InstrPC    = InstrValid ? pc_q[rd_q]  : '0;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed bench for instruction_fetch.
// Table-driven per-cycle vectors plus hand sequences for corner cases.
module tb_instruction_fetch;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [63:0] PCIn;
  logic        PCValid;
  logic        PCReady;
  logic        Flush;
  logic        MemReq;
  logic [63:0] MemAddr;
  logic        MemAck;
  logic [31:0] MemData;
  logic        InstrValid;
  logic [31:0] Instr;
  logic [63:0] InstrPC;
  logic        InstrReady;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        InstrFault;
  localparam bit B2B = 1'b0;
`else
  localparam bit B2B = 1'b1;
`endif

  instruction_fetch dut (
    .Clk(Clk), .Rst(Rst),
    .PCIn(PCIn), .PCValid(PCValid), .PCReady(PCReady),
    .Flush(Flush),
    .MemReq(MemReq), .MemAddr(MemAddr),
    .MemAck(MemAck), .MemData(MemData),
`ifdef FETCH_ALIGN_CHECK_EN
    .InstrFault(InstrFault),
`endif
    .InstrValid(InstrValid), .Instr(Instr),
    .InstrPC(InstrPC), .InstrReady(InstrReady)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        pcv;
    logic [63:0] pc;
    logic        fl;
    logic        ack;
    logic        rdy;
    logic        e_pcr;
    logic        e_req;
    logic [63:0] e_addr;
    logic        e_iv;
    logic [31:0] e_ins;
    logic [63:0] e_ipc;
  } vec_t;

  vec_t tbl[$];
  int total = 0;
  int bad = 0;

  function automatic logic [31:0] mem_word(logic [63:0] a);
    if (a == 64'h1000) return 32'h8B02_0020;
    return {16'hC0DE, a[15:0]};
  endfunction

  function automatic void add(logic pcv, logic [63:0] pc, logic fl,
                              logic ack, logic rdy, logic pcr, logic rq,
                              logic [63:0] ad, logic iv, logic [31:0] ins,
                              logic [63:0] ipc);
    vec_t v;
    v.pcv = pcv; v.pc = pc; v.fl = fl; v.ack = ack; v.rdy = rdy;
    v.e_pcr = pcr; v.e_req = rq; v.e_addr = ad;
    v.e_iv = iv; v.e_ins = ins; v.e_ipc = ipc;
    tbl.push_back(v);
  endfunction

  task automatic ck(string n, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, got, exp);
    end
  endtask

  task automatic cyc(logic pcv, logic [63:0] pc, logic fl,
                     logic ack, logic rdy);
    @(negedge Clk);
    PCValid    = pcv;
    PCIn       = pc;
    Flush      = fl;
    MemAck     = ack;
    InstrReady = rdy;
    MemData    = mem_word(MemAddr);
    #1;
  endtask

  initial begin
    logic [63:0] prev;
    logic [31:0] hi;
    logic        iv;

    Rst = 1'b0; PCIn = '0; PCValid = 1'b0; Flush = 1'b0;
    MemAck = 1'b0; MemData = '0; InstrReady = 1'b0;
    #1;
    ck("rst.pcr", 64'(PCReady), 64'd0);
    ck("rst.req", 64'(MemReq), 64'd0);
    ck("rst.addr", MemAddr, 64'd0);
    ck("rst.iv", 64'(InstrValid), 64'd0);
    ck("rst.ins", 64'(Instr), 64'd0);
    ck("rst.ipc", InstrPC, 64'd0);
    @(negedge Clk);
    #2 Rst = 1'b1;
    #1 ck("rel.pcr0", 64'(PCReady), 64'd0);

    // single fetch
    add(1, 64'h1000, 0, 0, 0, 1, 0, 64'h0, 0, 32'h0, 64'h0);
    add(0, 64'h0, 0, 1, 0, B2B, 1, 64'h1000, 0, 32'h0, 64'h0);
    add(0, 64'h0, 0, 0, 0, 1, 0, 64'h1000, 1, 32'h8B020020, 64'h1000);
    add(0, 64'h0, 0, 0, 1, 1, 0, 64'h1000, 1, 32'h8B020020, 64'h1000);
    add(0, 64'h0, 0, 0, 0, 1, 0, 64'h1000, 0, 32'h0, 64'h0);
    // fill with decode stalled
    for (int i = 0; i < 4; i++) begin
      prev = (i == 0) ? 64'h1000 : 64'(4 * (i - 1));
      iv   = (i > 0);
      hi   = iv ? 32'hC0DE0000 : 32'h0;
      add(1, 64'(4 * i), 0, 0, 0, 1, 0, prev, iv, hi, 64'h0);
      add(0, 64'h0, 0, 1, 0, B2B & (i < 3), 1, 64'(4 * i), iv, hi, 64'h0);
    end
    add(1, 64'h10, 0, 0, 0, 0, 0, 64'hC, 1, 32'hC0DE0000, 64'h0);
    add(1, 64'h10, 0, 0, 0, 0, 0, 64'hC, 1, 32'hC0DE0000, 64'h0);
    add(1, 64'h10, 0, 0, 1, 0, 0, 64'hC, 1, 32'hC0DE0000, 64'h0);
    add(1, 64'h10, 0, 0, 0, 1, 0, 64'hC, 1, 32'hC0DE0004, 64'h4);
    add(0, 64'h0, 0, 1, 0, 0, 1, 64'h10, 1, 32'hC0DE0004, 64'h4);
    add(0, 64'h0, 0, 0, 1, 0, 0, 64'h10, 1, 32'hC0DE0004, 64'h4);
    add(0, 64'h0, 0, 0, 1, 1, 0, 64'h10, 1, 32'hC0DE0008, 64'h8);
    add(0, 64'h0, 0, 0, 1, 1, 0, 64'h10, 1, 32'hC0DE000C, 64'hC);
    add(0, 64'h0, 0, 0, 1, 1, 0, 64'h10, 1, 32'hC0DE0010, 64'h10);
    add(0, 64'h0, 0, 0, 0, 1, 0, 64'h10, 0, 32'h0, 64'h0);

    for (int k = 0; k < tbl.size(); k++) begin
      cyc(tbl[k].pcv, tbl[k].pc, tbl[k].fl, tbl[k].ack, tbl[k].rdy);
      ck($sformatf("v%0d.pcr", k), 64'(PCReady), 64'(tbl[k].e_pcr));
      ck($sformatf("v%0d.req", k), 64'(MemReq), 64'(tbl[k].e_req));
      ck($sformatf("v%0d.addr", k), MemAddr, tbl[k].e_addr);
      ck($sformatf("v%0d.iv", k), 64'(InstrValid), 64'(tbl[k].e_iv));
      ck($sformatf("v%0d.ins", k), 64'(Instr), 64'(tbl[k].e_ins));
      ck($sformatf("v%0d.ipc", k), InstrPC, tbl[k].e_ipc);
    end

`ifndef FETCH_ALIGN_CHECK_EN
    // back-to-back accept on the push edge
    cyc(1, 64'h20, 0, 0, 0);
    ck("b2b.pcr0", 64'(PCReady), 64'd1);
    cyc(1, 64'h24, 0, 1, 0);
    ck("b2b.pcr1", 64'(PCReady), 64'd1);
    ck("b2b.addr1", MemAddr, 64'h20);
    cyc(0, 64'h0, 0, 1, 0);
    ck("b2b.req2", 64'(MemReq), 64'd1);
    ck("b2b.addr2", MemAddr, 64'h24);
    ck("b2b.ipc2", InstrPC, 64'h20);
    cyc(0, 64'h0, 0, 0, 1);
    ck("b2b.ipc3", InstrPC, 64'h20);
    cyc(0, 64'h0, 0, 0, 1);
    ck("b2b.ins4", 64'(Instr), 64'hC0DE0024);
    cyc(0, 64'h0, 0, 0, 0);
    ck("b2b.iv5", 64'(InstrValid), 64'd0);
`endif

    // flush while a request is outstanding
    cyc(1, 64'h40, 0, 0, 0);
    cyc(0, 64'h0, 0, 1, 0);
    cyc(1, 64'h44, 0, 0, 0);
    ck("fl.ipc", InstrPC, 64'h40);
    cyc(0, 64'h0, 0, 0, 0);
    ck("fl.req0", 64'(MemReq), 64'd1);
    ck("fl.addr0", MemAddr, 64'h44);
    cyc(0, 64'h0, 1, 0, 1);
    ck("fl.pcr1", 64'(PCReady), 64'd0);
    cyc(1, 64'h48, 0, 0, 0);
    ck("fl.drain.req", 64'(MemReq), 64'd1);
    ck("fl.drain.pcr", 64'(PCReady), 64'd0);
    ck("fl.drain.iv", 64'(InstrValid), 64'd0);
    cyc(0, 64'h0, 0, 1, 0);
    ck("fl.drain.req2", 64'(MemReq), 64'd1);
    cyc(0, 64'h0, 0, 0, 0);
    ck("fl.idle.req", 64'(MemReq), 64'd0);
    ck("fl.idle.iv", 64'(InstrValid), 64'd0);
    ck("fl.idle.pcr", 64'(PCReady), 64'd1);
    cyc(1, 64'h2000, 0, 0, 0);
    cyc(0, 64'h0, 0, 1, 0);
    ck("fl.new.addr", MemAddr, 64'h2000);
    cyc(0, 64'h0, 0, 0, 1);
    ck("fl.new.ins", 64'(Instr), 64'hC0DE2000);
    ck("fl.new.ipc", InstrPC, 64'h2000);
    // flush in the ack cycle drops the data
    cyc(1, 64'h50, 0, 0, 0);
    cyc(0, 64'h0, 1, 1, 0);
    ck("fla.pcr", 64'(PCReady), 64'd0);
    cyc(0, 64'h0, 0, 0, 1);
    ck("fla.iv", 64'(InstrValid), 64'd0);
    ck("fla.req", 64'(MemReq), 64'd0);
    cyc(0, 64'h0, 0, 0, 0);
    ck("fla.iv2", 64'(InstrValid), 64'd0);

    // push and pop together at count 2
    cyc(1, 64'h60, 0, 0, 0);
    cyc(0, 64'h0, 0, 1, 0);
    cyc(1, 64'h64, 0, 0, 0);
    cyc(0, 64'h0, 0, 1, 0);
    cyc(1, 64'h68, 0, 0, 0);
    ck("pp.ipc0", InstrPC, 64'h60);
    cyc(0, 64'h0, 0, 1, 1);
    ck("pp.ipc1", InstrPC, 64'h60);
    cyc(0, 64'h0, 0, 0, 0);
    ck("pp.ipc2", InstrPC, 64'h64);
    ck("pp.ins2", 64'(Instr), 64'hC0DE0064);
    cyc(0, 64'h0, 0, 0, 1);
    ck("pp.ipc3", InstrPC, 64'h64);
    cyc(0, 64'h0, 0, 0, 1);
    ck("pp.ipc4", InstrPC, 64'h68);
    cyc(0, 64'h0, 0, 0, 0);
    ck("pp.iv5", 64'(InstrValid), 64'd0);

    // misaligned PC
`ifdef FETCH_ALIGN_CHECK_EN
    cyc(1, 64'h1002, 0, 0, 0);
    ck("al.pcr", 64'(PCReady), 64'd1);
    cyc(0, 64'h0, 0, 0, 0);
    ck("al.req", 64'(MemReq), 64'd0);
    ck("al.iv", 64'(InstrValid), 64'd1);
    ck("al.ins", 64'(Instr), 64'd0);
    ck("al.ipc", InstrPC, 64'h1002);
    ck("al.flt", 64'(InstrFault), 64'd1);
    cyc(0, 64'h0, 0, 0, 1);
    cyc(0, 64'h0, 0, 0, 0);
    ck("al.flt0", 64'(InstrFault), 64'd0);
`else
    cyc(1, 64'h1002, 0, 0, 0);
    cyc(0, 64'h0, 0, 1, 0);
    ck("al.req", 64'(MemReq), 64'd1);
    ck("al.addr", MemAddr, 64'h1000);
    cyc(0, 64'h0, 0, 0, 1);
    ck("al.ipc", InstrPC, 64'h1000);
    ck("al.ins", 64'(Instr), 64'h8B020020);
`endif

    // reset in the middle of a request
    cyc(1, 64'h80, 0, 0, 0);
    cyc(0, 64'h0, 0, 1, 0);
    cyc(1, 64'h84, 0, 0, 0);
    cyc(0, 64'h0, 0, 0, 0);
    ck("mr.req", 64'(MemReq), 64'd1);
    ck("mr.iv", 64'(InstrValid), 64'd1);
    #1 Rst = 1'b0;
    #1;
    ck("mr.rst.req", 64'(MemReq), 64'd0);
    ck("mr.rst.iv", 64'(InstrValid), 64'd0);
    ck("mr.rst.pcr", 64'(PCReady), 64'd0);
    ck("mr.rst.addr", MemAddr, 64'd0);
    @(negedge Clk);
    #2 Rst = 1'b1;
    #1 ck("mr.rel.pcr0", 64'(PCReady), 64'd0);
    @(negedge Clk);
    #1;
    ck("mr.rel.pcr1", 64'(PCReady), 64'd1);
    ck("mr.rel.req", 64'(MemReq), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
